// File: rtl/multicycle_control_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : ctrl_pkg
//  Description : Opcodes, state encodings, select codes and control bundle
//                shared by the multicycle MIPS control FSM and its decoder.
//                ILLEGAL_OP_TRAP_EN selects trap-on-unknown-opcode behaviour.
//  Revision    : 1.0  initial release
// ============================================================================
package ctrl_pkg;

    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_j     = 6'b000010;
    localparam logic [5:0] c_op_jal   = 6'b000011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_bne   = 6'b000101;
    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_andi  = 6'b001100;
    localparam logic [5:0] c_op_ori   = 6'b001101;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;

    // IWB sits after TRAP so the other encodings keep their established values.
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEXEC = 4'd6,
        S_RTWB   = 4'd7,
        S_IEXEC  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_TRAP   = 4'd11,
        S_IWB    = 4'd12
    } state_t;

    localparam logic [2:0] c_aluop_add   = 3'b000;
    localparam logic [2:0] c_aluop_sub   = 3'b001;
    localparam logic [2:0] c_aluop_funct = 3'b010;
    localparam logic [2:0] c_aluop_and   = 3'b011;
    localparam logic [2:0] c_aluop_or    = 3'b100;

    localparam logic [1:0] c_regdst_rt  = 2'b00;
    localparam logic [1:0] c_regdst_rd  = 2'b01;
    localparam logic [1:0] c_regdst_ra  = 2'b10;

    localparam logic [1:0] c_wb_aluout  = 2'b00;
    localparam logic [1:0] c_wb_mdr     = 2'b01;
    localparam logic [1:0] c_wb_pc      = 2'b10;

    localparam logic [1:0] c_srcb_rt      = 2'b00;
    localparam logic [1:0] c_srcb_four    = 2'b01;
    localparam logic [1:0] c_srcb_imm     = 2'b10;
    localparam logic [1:0] c_srcb_imm_sl2 = 2'b11;

    localparam logic [1:0] c_pcsrc_alu    = 2'b00;
    localparam logic [1:0] c_pcsrc_aluout = 2'b01;
    localparam logic [1:0] c_pcsrc_jump   = 2'b10;

`ifdef ILLEGAL_OP_TRAP_EN
    localparam bit c_trap_en = 1'b1;
`else
    localparam bit c_trap_en = 1'b0;
`endif

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
    } ctrl_t;

    // Execute-phase entry state for an opcode seen in DECODE.
    function automatic state_t op_target(input logic [5:0] op);
        case (op)
            c_op_lw, c_op_sw:               return S_MEMADR;
            c_op_rtype:                     return S_RTEXEC;
            c_op_addi, c_op_andi, c_op_ori: return S_IEXEC;
            c_op_beq, c_op_bne:             return S_BRANCH;
            c_op_j, c_op_jal:               return S_JUMP;
            default:                        return c_trap_en ? S_TRAP : S_FETCH;
        endcase
    endfunction

    function automatic logic op_unknown(input logic [5:0] op);
        state_t w_t;
        w_t = op_target(op);
        return (w_t == S_FETCH) || (w_t == S_TRAP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_outdec.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl_outdec
//  Description : Combinational decode of state, latched opcode and mem_ready
//                into datapath controls. ILLEGAL_OP_TRAP_EN adds o_illegal_op.
//  Revision    : 1.0  initial release
// ============================================================================
module multicycle_ctrl_outdec
    import ctrl_pkg::*;
(
    input  logic       i_rst,
    input  state_t     i_state,
    input  logic [5:0] i_op_latched,
    input  logic       i_op_unknown,
    input  logic       i_mem_ready,
`ifdef ILLEGAL_OP_TRAP_EN
    output logic       o_illegal_op,
`endif
    output ctrl_t      o_ctrl
);

    ctrl_t w_ctrl;

    always_comb begin
        w_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                w_ctrl.mem_read  = 1'b1;
                w_ctrl.alu_src_b = c_srcb_four;
                w_ctrl.alu_op    = c_aluop_add;
                w_ctrl.pc_source = c_pcsrc_alu;
                w_ctrl.ir_write  = i_mem_ready;
                w_ctrl.pc_write  = i_mem_ready;
            end
            S_DECODE: begin
                w_ctrl.alu_src_b  = c_srcb_imm_sl2;
                w_ctrl.alu_op     = c_aluop_add;
                w_ctrl.instr_done = i_op_unknown && !c_trap_en;
            end
            S_MEMADR: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = c_srcb_imm;
                w_ctrl.alu_op    = c_aluop_add;
            end
            S_MEMRD: begin
                w_ctrl.mem_read = 1'b1;
                w_ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.reg_dst    = c_regdst_rt;
                w_ctrl.mem_to_reg = c_wb_mdr;
                w_ctrl.instr_done = 1'b1;
            end
            S_MEMWR: begin
                w_ctrl.mem_write  = 1'b1;
                w_ctrl.iord       = 1'b1;
                w_ctrl.instr_done = i_mem_ready;
            end
            S_RTEXEC: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = c_srcb_rt;
                w_ctrl.alu_op    = c_aluop_funct;
            end
            S_RTWB: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.reg_dst    = c_regdst_rd;
                w_ctrl.mem_to_reg = c_wb_aluout;
                w_ctrl.instr_done = 1'b1;
            end
            S_IEXEC: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = c_srcb_imm;
                if (i_op_latched == c_op_andi)
                    w_ctrl.alu_op = c_aluop_and;
                else if (i_op_latched == c_op_ori)
                    w_ctrl.alu_op = c_aluop_or;
                else
                    w_ctrl.alu_op = c_aluop_add;
            end
            S_IWB: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.reg_dst    = c_regdst_rt;
                w_ctrl.mem_to_reg = c_wb_aluout;
                w_ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                w_ctrl.alu_src_a     = 1'b1;
                w_ctrl.alu_src_b     = c_srcb_rt;
                w_ctrl.alu_op        = c_aluop_sub;
                w_ctrl.pc_write_cond = 1'b1;
                w_ctrl.pc_source     = c_pcsrc_aluout;
                w_ctrl.branch_ne     = (i_op_latched == c_op_bne);
                w_ctrl.instr_done    = 1'b1;
            end
            S_JUMP: begin
                w_ctrl.pc_write   = 1'b1;
                w_ctrl.pc_source  = c_pcsrc_jump;
                w_ctrl.instr_done = 1'b1;
                // jal links while PC still holds PC+4
                if (i_op_latched == c_op_jal) begin
                    w_ctrl.reg_write  = 1'b1;
                    w_ctrl.reg_dst    = c_regdst_ra;
                    w_ctrl.mem_to_reg = c_wb_pc;
                end
            end
            default: w_ctrl = '0;
        endcase
    end

    assign o_ctrl = i_rst ? '0 : w_ctrl;

`ifdef ILLEGAL_OP_TRAP_EN
    assign o_illegal_op = !i_rst && (i_state == S_TRAP);
`endif

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : Multicycle MIPS main control FSM with memory wait states.
//                ILLEGAL_OP_TRAP_EN traps unknown opcodes (adds illegal_op).
//  Revision    : 1.0  initial release
// ============================================================================
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 3,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OP_W-1:0]    opcode,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               BranchNE,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic [1:0]         RegDst,
    output logic [1:0]         MemtoReg,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [1:0]         PCSource,
    output logic               instr_done,
`ifdef ILLEGAL_OP_TRAP_EN
    output logic               illegal_op,
`endif
    output logic [STATE_W-1:0] state_o
);

    state_t          r_state;
    state_t          w_next;
    logic [OP_W-1:0] r_op;
    logic [5:0]      w_op;
    logic [5:0]      w_op_latched;
    ctrl_t           w_ctrl;

    assign w_op         = 6'(opcode);
    assign w_op_latched = 6'(r_op);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  if (mem_ready) w_next = S_DECODE;
            S_DECODE: w_next = op_target(w_op);
            S_MEMADR: w_next = (w_op_latched == c_op_sw) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) w_next = S_MEMWB;
            S_MEMWR:  if (mem_ready) w_next = S_FETCH;
            S_RTEXEC: w_next = S_RTWB;
            S_IEXEC:  w_next = S_IWB;
            S_TRAP:   w_next = S_TRAP;
            S_MEMWB, S_RTWB, S_IWB, S_BRANCH, S_JUMP: w_next = S_FETCH;
            default:  w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_op    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE)
                r_op <= opcode;
        end
    end

    multicycle_ctrl_outdec u_outdec (
        .i_rst        (rst),
        .i_state      (r_state),
        .i_op_latched (w_op_latched),
        .i_op_unknown (op_unknown(w_op)),
        .i_mem_ready  (mem_ready),
`ifdef ILLEGAL_OP_TRAP_EN
        .o_illegal_op (illegal_op),
`endif
        .o_ctrl       (w_ctrl)
    );

    assign PCWrite     = w_ctrl.pc_write;
    assign PCWriteCond = w_ctrl.pc_write_cond;
    assign BranchNE    = w_ctrl.branch_ne;
    assign IorD        = w_ctrl.iord;
    assign MemRead     = w_ctrl.mem_read;
    assign MemWrite    = w_ctrl.mem_write;
    assign IRWrite     = w_ctrl.ir_write;
    assign RegDst      = w_ctrl.reg_dst;
    assign MemtoReg    = w_ctrl.mem_to_reg;
    assign RegWrite    = w_ctrl.reg_write;
    assign ALUSrcA     = w_ctrl.alu_src_a;
    assign ALUSrcB     = w_ctrl.alu_src_b;
    assign ALUOp       = ALUOP_W'(w_ctrl.alu_op);
    assign PCSource    = w_ctrl.pc_source;
    assign instr_done  = w_ctrl.instr_done;
    assign state_o     = STATE_W'(r_state);

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_control
//  Description : Self-checking bench for multicycle_control; builds expected
//                per-cycle control vectors from instruction-level rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multicycle_control;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
    } ctl_t;

    typedef struct {
        logic [3:0] st;
        ctl_t       c;
        logic       rdy;
        logic [5:0] op;
    } rec_t;

`ifdef ILLEGAL_OP_TRAP_EN
    localparam bit TB_TRAP = 1'b1;
`else
    localparam bit TB_TRAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = '0;
    logic       mem_ready = 1'b0;
    logic PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite;
    logic [1:0] RegDst, MemtoReg, ALUSrcB, PCSource;
    logic RegWrite, ALUSrcA, instr_done;
    logic [2:0] ALUOp;
    logic [3:0] state_o;
`ifdef ILLEGAL_OP_TRAP_EN
    logic illegal_op;
`endif
    ctl_t obs;

    int n_tests = 0;
    int n_fail  = 0;
    rec_t q[$];

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNE(BranchNE),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .instr_done(instr_done),
`ifdef ILLEGAL_OP_TRAP_EN
        .illegal_op(illegal_op),
`endif
        .state_o(state_o)
    );

    assign obs = {PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite,
                  RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done};

    // mode: 0 drive ready low, 1 drive ready high, 2 ready is a don't-care (random)
    function automatic void add(input logic [3:0] st, input ctl_t c, input int mode,
                                input logic [5:0] op);
        rec_t r;
        r.st  = st;
        r.c   = c;
        r.rdy = (mode == 2) ? logic'($urandom_range(0, 1)) : (mode == 1);
        r.op  = op;
        q.push_back(r);
    endfunction

    // Expected cycle-by-cycle behaviour of one whole instruction.
    function automatic void build(input logic [5:0] op, input int fw, input int mw);
        ctl_t c;
        logic [5:0] junk;
        bit known;
        junk = 6'($urandom);
        known = (op == 6'h00) || (op == 6'h02) || (op == 6'h03) || (op == 6'h04) ||
                (op == 6'h05) || (op == 6'h08) || (op == 6'h0C) || (op == 6'h0D) ||
                (op == 6'h23) || (op == 6'h2B);
        c = '0; c.mem_read = 1; c.alu_src_b = 2'b01;
        for (int i = 0; i < fw; i++) add(4'd0, c, 0, 6'($urandom));
        c.ir_write = 1; c.pc_write = 1;
        add(4'd0, c, 1, 6'($urandom));
        c = '0; c.alu_src_b = 2'b11; c.instr_done = !known && !TB_TRAP;
        add(4'd1, c, 2, op);
        if (op == 6'h23 || op == 6'h2B) begin
            c = '0; c.alu_src_a = 1; c.alu_src_b = 2'b10;
            add(4'd2, c, 2, op);
            c = '0; c.iord = 1;
            if (op == 6'h23) c.mem_read = 1; else c.mem_write = 1;
            for (int i = 0; i < mw; i++) add((op == 6'h23) ? 4'd3 : 4'd5, c, 0, op);
            if (op == 6'h2B) c.instr_done = 1;
            add((op == 6'h23) ? 4'd3 : 4'd5, c, 1, op);
            if (op == 6'h23) begin
                c = '0; c.reg_write = 1; c.mem_to_reg = 2'b01; c.instr_done = 1;
                add(4'd4, c, 2, op);
            end
        end else if (op == 6'h00) begin
            c = '0; c.alu_src_a = 1; c.alu_op = 3'b010;
            add(4'd6, c, 2, op);
            c = '0; c.reg_write = 1; c.reg_dst = 2'b01; c.instr_done = 1;
            add(4'd7, c, 2, op);
        end else if (op == 6'h08 || op == 6'h0C || op == 6'h0D) begin
            c = '0; c.alu_src_a = 1; c.alu_src_b = 2'b10;
            c.alu_op = (op == 6'h0C) ? 3'b011 : (op == 6'h0D) ? 3'b100 : 3'b000;
            add(4'd8, c, 2, junk);
            c = '0; c.reg_write = 1; c.instr_done = 1;
            add(4'd12, c, 2, 6'($urandom));
        end else if (op == 6'h04 || op == 6'h05) begin
            c = '0; c.alu_src_a = 1; c.alu_op = 3'b001; c.pc_write_cond = 1;
            c.pc_source = 2'b01; c.instr_done = 1; c.branch_ne = (op == 6'h05);
            add(4'd9, c, 2, junk);
        end else if (op == 6'h02 || op == 6'h03) begin
            c = '0; c.pc_write = 1; c.pc_source = 2'b10; c.instr_done = 1;
            if (op == 6'h03) begin
                c.reg_write = 1; c.reg_dst = 2'b10; c.mem_to_reg = 2'b10;
            end
            add(4'd10, c, 2, junk);
        end
    endfunction

    // Plays the first n queued cycles (all when n < 0), checking each cycle.
    task automatic play(input string name, input int n);
        int lim;
        lim = (n < 0 || n > q.size()) ? q.size() : n;
        for (int i = 0; i < lim; i++) begin
            opcode    = q[i].op;
            mem_ready = q[i].rdy;
            @(negedge clk);
            n_tests++;
            if (state_o !== q[i].st) begin
                n_fail++;
                $display("FAIL %s cyc%0d state: got %0d want %0d", name, i, state_o, q[i].st);
            end
            n_tests++;
            if (obs !== q[i].c) begin
                n_fail++;
                $display("FAIL %s cyc%0d controls: got %h want %h", name, i, obs, q[i].c);
            end
            @(posedge clk); #1;
        end
        q.delete();
    endtask

    task automatic test_reset;
        rst = 1; mem_ready = 1; opcode = 6'h23;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (obs !== '0 || state_o !== 4'd0) begin
            n_fail++;
            $display("FAIL reset: controls %h state %0d want 0 0", obs, state_o);
        end
        rst = 0;
    endtask

    task automatic test_rtype;
        build(6'h00, 0, 0); play("rtype", -1);
    endtask

    task automatic test_lw_waits;
        build(6'h23, 3, 2);
        n_tests++;
        if (q.size() != 10 || q[9].st !== 4'd4) begin
            n_fail++;
            $display("FAIL lw_model: len %0d want 10", q.size());
        end
        play("lw_waits", -1);
    endtask

    task automatic test_branch;
        build(6'h05, 0, 0); play("bne", -1);
        build(6'h04, 1, 0); play("beq", -1);
    endtask

    task automatic test_jal;
        build(6'h03, 0, 0); play("jal", -1);
        build(6'h00, 0, 0); play("after_jal", -1);
    endtask

    task automatic test_iexec;
        build(6'h0D, 0, 0); play("ori", -1);
        build(6'h0C, 0, 0); play("andi", -1);
        build(6'h08, 0, 0); play("addi", -1);
    endtask

    task automatic test_illegal;
        build(6'h3F, 0, 0); play("illegal_decode", -1);
`ifdef ILLEGAL_OP_TRAP_EN
        for (int i = 0; i < 3; i++) begin
            mem_ready = logic'($urandom_range(0, 1)); opcode = 6'($urandom);
            @(negedge clk);
            n_tests++;
            if (illegal_op !== 1'b1 || state_o !== 4'd11 || obs !== '0) begin
                n_fail++;
                $display("FAIL trap_hold: illegal %b state %0d ctl %h want 1 11 0",
                         illegal_op, state_o, obs);
            end
            @(posedge clk); #1;
        end
        rst = 1; #1;
        n_tests++;
        if (illegal_op !== 1'b0 || state_o !== 4'd0) begin
            n_fail++;
            $display("FAIL trap_reset: illegal %b state %0d want 0 0", illegal_op, state_o);
        end
        @(posedge clk); #1; rst = 0;
`endif
        build(6'h00, 0, 0); play("after_illegal", -1);
    endtask

    task automatic test_reset_in_memwr;
        build(6'h2B, 0, 5);
        play("sw_pre", 4);
        mem_ready = 0; #2;
        n_tests++;
        if (MemWrite !== 1'b1 || state_o !== 4'd5) begin
            n_fail++;
            $display("FAIL memwr_pre: MemWrite %b state %0d want 1 5", MemWrite, state_o);
        end
        rst = 1; mem_ready = 1; #1;
        n_tests++;
        if (obs !== '0 || state_o !== 4'd0) begin
            n_fail++;
            $display("FAIL memwr_rst: controls %h state %0d want 0 0", obs, state_o);
        end
        @(posedge clk); #1; rst = 0;
        build(6'h23, 1, 1); play("after_rst", -1);
    endtask

    task automatic test_random;
        logic [5:0] ops[11];
        logic [5:0] op;
        ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h3F};
        for (int k = 0; k < 150; k++) begin
            op = ops[$urandom_range(0, TB_TRAP ? 9 : 10)];
            build(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            play("random", -1);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_waits();
        test_branch();
        test_jal();
        test_iexec();
        test_reset_in_memwr();
        test_random();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle MIPS main control FSM, successor to the single-cycle opcode decoder.
- Sequences fetch / decode / execute / memory / writeback per instruction over a shared memory and ALU datapath.
- Adds a memory handshake (wait states), bne, sw, a wider ALU-op code and an instruction-retire pulse.
- Sits between the instruction register's opcode field and the datapath mux/enable controls.

Parameters:
- OP_W, 6, opcode field width.
- ALUOP_W, 3, ALU-operation code width; must be at least 3.
- STATE_W, 4, state register width; must be at least 4.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  OP_W  instruction[31:26] from the instruction register; valid from DECODE onward.
- mem_ready  in  1  memory completes the current access this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  conditional PC load (branch).
- BranchNE  out  1  invert the zero condition (bne).
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  instruction register load.
- RegDst  out  2  write-register select: 00 = rt, 01 = rd, 10 = $31.
- MemtoReg  out  2  write-data select: 00 = ALUOut, 01 = MDR, 10 = PC.
- RegWrite  out  1  register-file write enable.
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = rs.
- ALUSrcB  out  2  ALU B select: 00 = rt, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- ALUOp  out  ALUOP_W  ALU op: 000 add, 001 sub, 010 funct-decode, 011 and, 100 or.
- PCSource  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction.
- state_o  out  STATE_W  current state, for debug.

Behaviour:
- Moore FSM with a single state register. Outputs decode from the current state. Handshake-qualified outputs (listed below) also use mem_ready.
- rst high: state forced to FETCH asynchronously, and every output is forced to 0 combinationally while rst is high.
- Reset asserted mid-instruction abandons that instruction; no pending write completes.
- After rst deasserts, the first cycle is FETCH.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=add, PCSource=00.
  - IRWrite and PCWrite assert only in a cycle where mem_ready=1, and the FSM then moves to DECODE.
  - Otherwise the FSM holds in FETCH with no limit on the wait.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=add (precomputes the branch target). Next state by opcode:
  - lw (100011), sw (101011) -> MEMADR
  - R-type (000000) -> RTEXEC
  - addi (001000), andi (001100), ori (001101) -> IEXEC
  - beq (000100), bne (000101) -> BRANCH
  - j (000010), jal (000011) -> JUMP
  - any other opcode -> see Optional Feature.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=add; then lw -> MEMRD, sw -> MEMWR.
- MEMRD: MemRead=1, IorD=1; hold until mem_ready, then -> MEMWB.
- MEMWB: RegWrite=1, RegDst=00, MemtoReg=01, instr_done=1; then -> FETCH.
- MEMWR: MemWrite=1, IorD=1; hold until mem_ready. In the mem_ready cycle instr_done=1 and the FSM moves to FETCH.
- RTEXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=funct-decode; then -> RTWB.
- RTWB: RegWrite=1, RegDst=01, MemtoReg=00, instr_done=1; then -> FETCH.
- IEXEC: ALUSrcA=1, ALUSrcB=10; ALUOp = add (addi), and (andi) or or (ori); then -> IWB.
  - ALUOp comes from the opcode latched at the DECODE->IEXEC transition.
- IWB: RegWrite=1, RegDst=00, MemtoReg=00, instr_done=1; then -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=sub, PCWriteCond=1, PCSource=01, instr_done=1; then -> FETCH.
  - BranchNE=1 when the latched opcode is bne.
- JUMP: PCWrite=1, PCSource=10, instr_done=1; then -> FETCH.
  - For jal, also RegWrite=1, RegDst=10, MemtoReg=10 in the same cycle. The PC still holds PC+4, so this writes PC+4 to $31.
- Latched opcode: a register captures opcode on every DECODE cycle; IEXEC, BRANCH and JUMP use it.
- Outputs not listed for a state are 0.
- Cycles per instruction with mem_ready tied to 1:
  - lw 5
  - sw 4
  - R-type / I-type ALU 4
  - beq / bne 3
  - j / jal 3

Optional Feature:
- Macro: ILLEGAL_OP_TRAP_EN
- Defined: an unknown opcode in DECODE moves the FSM to TRAP.
  - TRAP asserts the extra output illegal_op=1 and holds all other outputs at 0.
  - The FSM stays in TRAP until rst.
- Undefined: an unknown opcode is treated as a NOP. DECODE moves to FETCH with instr_done=1. No illegal_op port exists.

Decomposition:
- Package ctrl_pkg holds:
  - opcode constants
  - state encodings: FETCH=0 … JUMP=10, TRAP=11
  - ALUOp codes
  - RegDst, MemtoReg, ALUSrcB and PCSource select codes
- One natural sub-module: multicycle_ctrl_outdec, a combinational decode of state, latched opcode and mem_ready to all control outputs. The FSM next-state logic stays in the top module.

Test Plan:
- mem_ready=1, run add (opcode 000000) -> states FETCH, DECODE, RTEXEC, RTWB; RegWrite=1 and RegDst=01 in cycle 4 only; instr_done pulses once in cycle 4.
- lw with mem_ready low for 3 cycles in FETCH and 2 in MEMRD -> IRWrite/PCWrite only in the ready cycle; MEMWB reached in cycle 10; MemtoReg=01.
- bne (000101) -> BRANCH with PCWriteCond=1, BranchNE=1, ALUOp=001, PCSource=01; beq gives BranchNE=0.
- jal (000011) -> JUMP with PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=10; back in FETCH next cycle.
- ori (001101) then andi (001100) -> ALUOp 100 then 011 in IEXEC, ALUSrcB=10.
- Opcode 111111 -> with ILLEGAL_OP_TRAP_EN, illegal_op=1 held until rst; without it, FETCH in the next cycle with instr_done=1. Also assert rst in MEMWR -> all outputs 0 immediately, FETCH after release.
